// File: rtl/fml_arbiter.sv
// Four-master round-robin arbiter in front of the single FML 8x16 SDRAM port.
// Latency: one IDLE arbitration cycle from stb to s_stb; acks are combinational from s_ack.
// Backpressure: a master holds stb until its ack; the slave stalls by withholding s_ack in REQ.
module fml_arbiter #(
    parameter int sdram_depth = 23,
    parameter int data_hold   = 8
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,

    input  logic [sdram_depth-1:0] m0_adr,
    input  logic                   m0_stb,
    input  logic                   m0_we,
    input  logic [1:0]             m0_sel,
    input  logic [15:0]            m0_di,
    output logic                   m0_ack,
    output logic [15:0]            m0_do,

    input  logic [sdram_depth-1:0] m1_adr,
    input  logic                   m1_stb,
    input  logic                   m1_we,
    input  logic [1:0]             m1_sel,
    input  logic [15:0]            m1_di,
    output logic                   m1_ack,
    output logic [15:0]            m1_do,

    input  logic [sdram_depth-1:0] m2_adr,
    input  logic                   m2_stb,
    input  logic                   m2_we,
    input  logic [1:0]             m2_sel,
    input  logic [15:0]            m2_di,
    output logic                   m2_ack,
    output logic [15:0]            m2_do,

    input  logic [sdram_depth-1:0] m3_adr,
    input  logic                   m3_stb,
    input  logic                   m3_we,
    input  logic [1:0]             m3_sel,
    input  logic [15:0]            m3_di,
    output logic                   m3_ack,
    output logic [15:0]            m3_do,

    output logic [sdram_depth-1:0] s_adr,
    output logic                   s_stb,
    output logic                   s_we,
    output logic [1:0]             s_sel,
    output logic [15:0]            s_di,
    input  logic                   s_ack,
    input  logic [15:0]            s_do
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // Beat 0 is the ack cycle itself, so the counter covers the remaining beats.
    localparam logic [3:0] HOLD_INIT = 4'(data_hold - 1);

    logic [1:0] r_state;
    logic [1:0] r_owner;
    logic [1:0] r_last;
    logic [3:0] r_cnt;

    logic [sdram_depth-1:0] w_adr [4];
    logic [3:0]             w_stb;
    logic [3:0]             w_we;
    logic [1:0]             w_sel [4];
    logic [15:0]            w_di  [4];

    logic       w_any;
    logic [1:0] w_grant;
    logic       w_found;
    logic       w_in_req;
    logic       w_ack_en;

    assign w_adr[0] = m0_adr;
    assign w_adr[1] = m1_adr;
    assign w_adr[2] = m2_adr;
    assign w_adr[3] = m3_adr;
    assign w_stb    = {m3_stb, m2_stb, m1_stb, m0_stb};
    assign w_we     = {m3_we, m2_we, m1_we, m0_we};
    assign w_sel[0] = m0_sel;
    assign w_sel[1] = m1_sel;
    assign w_sel[2] = m2_sel;
    assign w_sel[3] = m3_sel;
    assign w_di[0]  = m0_di;
    assign w_di[1]  = m1_di;
    assign w_di[2]  = m2_di;
    assign w_di[3]  = m3_di;

    // The data path follows the owner in every state so write beats keep flowing in HOLD.
    assign s_adr = w_adr[r_owner];
    assign s_we  = w_we[r_owner];
    assign s_sel = w_sel[r_owner];
    assign s_di  = w_di[r_owner];

    assign w_in_req = (r_state == ST_REQ);
    assign s_stb    = w_in_req & w_stb[r_owner];

    // A slave ack arriving while the arbiter is being reset is not forwarded.
    assign w_ack_en = w_in_req & s_ack & ~sys_rst;
    assign m0_ack   = w_ack_en & (r_owner == 2'd0);
    assign m1_ack   = w_ack_en & (r_owner == 2'd1);
    assign m2_ack   = w_ack_en & (r_owner == 2'd2);
    assign m3_ack   = w_ack_en & (r_owner == 2'd3);

    // Read data is broadcast; each master qualifies it with its own ack/data phase.
    assign m0_do = s_do;
    assign m1_do = s_do;
    assign m2_do = s_do;
    assign m3_do = s_do;

    // Round-robin scan starting just after the last served master, wrapping modulo 4.
    always_comb begin
        logic [1:0] v_idx;
        v_idx   = '0;
        w_any   = |w_stb;
        w_grant = r_last + 2'd1;
        w_found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            v_idx = r_last + 2'(i);
            if (!w_found && w_stb[v_idx]) begin
                w_grant = v_idx;
                w_found = 1'b1;
            end
        end
    end

    // Burst-level FSM: arbitrate in IDLE, wait for the slave in REQ, freeze the mux in HOLD.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
            r_owner <= 2'd0;
            r_last  <= 2'd3;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_owner <= w_grant;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (s_ack) begin
                        r_last  <= r_owner;
                        r_cnt   <= HOLD_INIT;
                        r_state <= (data_hold == 1) ? ST_IDLE : ST_HOLD;
                    end else if (!w_stb[r_owner]) begin
                        // Master withdrew without an ack; its turn is not consumed.
                        r_state <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fml_arbiter.sv
// Self-checking bench for fml_arbiter: directed scenarios plus randomized traffic.
// Latency: checks DUT outputs against a burst-level reference model every cycle.
// Backpressure: masters hold stb until ack; the slave acks at random, including spuriously.
module tb_fml_arbiter;

    localparam int AW = 23;
    localparam int DH = 8;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic [AW-1:0] adr [4];
    logic [3:0]    stb;
    logic [3:0]    we;
    logic [1:0]    sel [4];
    logic [15:0]   di  [4];
    logic [3:0]    ack;
    logic [15:0]   mdo [4];
    logic [AW-1:0] s_adr;
    logic          s_stb;
    logic          s_we;
    logic [1:0]    s_sel;
    logic [15:0]   s_di;
    logic          s_ack;
    logic [15:0]   s_do;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 sys_clk = ~sys_clk;

    fml_arbiter #(.sdram_depth(AW), .data_hold(DH)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m0_adr(adr[0]), .m0_stb(stb[0]), .m0_we(we[0]), .m0_sel(sel[0]), .m0_di(di[0]),
        .m0_ack(ack[0]), .m0_do(mdo[0]),
        .m1_adr(adr[1]), .m1_stb(stb[1]), .m1_we(we[1]), .m1_sel(sel[1]), .m1_di(di[1]),
        .m1_ack(ack[1]), .m1_do(mdo[1]),
        .m2_adr(adr[2]), .m2_stb(stb[2]), .m2_we(we[2]), .m2_sel(sel[2]), .m2_di(di[2]),
        .m2_ack(ack[2]), .m2_do(mdo[2]),
        .m3_adr(adr[3]), .m3_stb(stb[3]), .m3_we(we[3]), .m3_sel(sel[3]), .m3_di(di[3]),
        .m3_ack(ack[3]), .m3_do(mdo[3]),
        .s_adr(s_adr), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel), .s_di(s_di),
        .s_ack(s_ack), .s_do(s_do)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a burst is either waiting for the slave, or the port is
    // unavailable until cycle md_free_at (ack cycle + data_hold), or it is free.
    bit            mdl_on     = 1'b0;
    bit            md_wait    = 1'b0;
    int            md_owner   = 0;
    int            md_last    = 3;
    int            md_free_at = 0;
    int            cyc        = 0;
    logic [AW-1:0] e_adr;
    logic          e_stb, e_we;
    logic [1:0]    e_sel;
    logic [15:0]   e_di;
    logic [3:0]    e_ack;

    always @(negedge sys_clk) begin
        e_adr = adr[md_owner];
        e_we  = we[md_owner];
        e_sel = sel[md_owner];
        e_di  = di[md_owner];
        e_stb = md_wait && stb[md_owner];
        e_ack = (md_wait && s_ack && !sys_rst) ? (4'b0001 << md_owner) : 4'b0000;
        if (mdl_on) begin
            chk("s_adr", 64'(s_adr), 64'(e_adr));
            chk("s_we",  64'(s_we),  64'(e_we));
            chk("s_sel", 64'(s_sel), 64'(e_sel));
            chk("s_di",  64'(s_di),  64'(e_di));
            chk("s_stb", 64'(s_stb), 64'(e_stb));
            chk("acks",  64'(ack),   64'(e_ack));
            chk("m_do",  {mdo[3], mdo[2], mdo[1], mdo[0]}, {4{s_do}});
        end
        if (sys_rst) begin
            md_wait = 1'b0; md_owner = 0; md_last = 3; md_free_at = 0;
        end else if (md_wait) begin
            if (s_ack) begin
                md_last    = md_owner;
                md_wait    = 1'b0;
                md_free_at = cyc + DH;
            end else if (!stb[md_owner]) begin
                md_wait = 1'b0;
            end
        end else if (cyc >= md_free_at && stb != 4'b0000) begin
            for (int k = 1; k <= 4; k++) begin
                if (!md_wait && stb[(md_last + k) % 4]) begin
                    md_owner = (md_last + k) % 4;
                    md_wait  = 1'b1;
                end
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic look();
        @(negedge sys_clk);
        #1;
    endtask

    int       exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int       order     [8];
    int       n_ack;
    logic [3:0] ack_seen;

    initial begin
        sys_rst = 1'b1; stb = '0; we = '0; s_ack = 1'b0; s_do = '0;
        for (int i = 0; i < 4; i++) begin
            adr[i] = '0; sel[i] = '0; di[i] = '0;
        end
        adr[0] = 23'h3;
        tick;
        mdl_on = 1'b1;
        tick;
        sys_rst = 1'b0;
        look;
        chk("rst_s_stb", 64'(s_stb), 64'd0);
        chk("rst_acks",  64'(ack),   64'd0);
        chk("rst_s_adr", 64'(s_adr), 64'h3);

        // m2 alone: grant, ack at t3, seven HOLD cycles, free again at t11.
        tick; stb[2] = 1'b1; we[2] = 1'b0; adr[2] = 23'h100;          // t0
        look; chk("m2_t0_stb", 64'(s_stb), 64'd0);
        tick; look;                                                    // t1
        chk("m2_t1_stb", 64'(s_stb), 64'd1);
        chk("m2_t1_adr", 64'(s_adr), 64'h100);
        tick; look;                                                    // t2
        tick; s_ack = 1'b1; s_do = 16'h1234;                           // t3
        look;
        chk("m2_t3_ack", 64'(ack), 64'b0100);
        chk("m2_t3_mdl_ack", 64'(e_ack), 64'b0100);
        chk("m2_t3_do", 64'(mdo[2]), 64'h1234);
        tick; s_ack = 1'b0; stb[2] = 1'b0; sel[2] = 2'b10; sel[0] = 2'b01;  // t4
        look; chk("m2_t4_stb", 64'(s_stb), 64'd0);
        tick; tick; look;                                              // t6
        chk("m2_hold_sel", 64'(s_sel), 64'b10);
        tick; tick; tick;                                              // t9
        tick; stb[0] = 1'b1; adr[0] = 23'h2AAA;                        // t10
        look;
        chk("m2_t10_adr", 64'(s_adr), 64'h100);
        chk("m2_t10_stb", 64'(s_stb), 64'd0);
        tick; look;                                                    // t11
        chk("t11_stb", 64'(s_stb), 64'd0);
        chk("t11_mdl_stb", 64'(e_stb), 64'd0);
        tick; look;                                                    // t12
        chk("t12_stb", 64'(s_stb), 64'd1);
        chk("t12_adr", 64'(s_adr), 64'h2AAA);
        chk("t12_mdl_last", 64'(md_last), 64'd2);
        tick; s_ack = 1'b1;                                            // t13
        look; chk("t13_ack", 64'(ack), 64'b0001);
        tick; s_ack = 1'b0; stb[0] = 1'b0;                             // t14 HOLD cnt=7
        tick; tick;                                                    // t16
        tick; sys_rst = 1'b1;                                          // t17 HOLD cnt=4
        look;
        chk("rst_hold_ack", 64'(ack), 64'd0);
        chk("rst_hold_stb", 64'(s_stb), 64'd0);
        tick; sys_rst = 1'b0;                                          // t18
        stb[0] = 1'b1; adr[0] = 23'h55; stb[1] = 1'b1; adr[1] = 23'h77;
        look; chk("t18_stb", 64'(s_stb), 64'd0);
        tick; look;                                                    // t19
        chk("t19_stb", 64'(s_stb), 64'd1);
        chk("t19_adr_last3", 64'(s_adr), 64'h55);

        // All four masters request continuously with an always-acking slave.
        tick; sys_rst = 1'b1;
        tick; sys_rst = 1'b0; stb = 4'hF; s_ack = 1'b1;
        n_ack = 0;
        for (int c = 0; c < 200 && n_ack < 8; c++) begin
            look;
            if (ack != 4'b0000) begin
                chk("fair_onehot", 64'($countones(ack)), 64'd1);
                for (int i = 0; i < 4; i++) if (ack[i]) order[n_ack] = i;
                n_ack++;
            end
            tick;
        end
        chk("fair_count", 64'(n_ack), 64'd8);
        for (int i = 0; i < 8 && i < n_ack; i++)
            chk("fair_order", 64'(order[i]), 64'(exp_order[i]));

        // Randomized traffic: protocol-abiding masters, rare withdrawals and resets.
        sys_rst = 1'b1; stb = '0; s_ack = 1'b0;
        tick; sys_rst = 1'b0;
        ack_seen = '0;
        for (int c = 0; c < 3000; c++) begin
            tick;
            sys_rst = ($urandom_range(0, 299) == 0);
            s_ack   = ($urandom_range(0, 2) == 0);
            s_do    = 16'($urandom);
            for (int i = 0; i < 4; i++) begin
                sel[i] = 2'($urandom);
                di[i]  = 16'($urandom);
                if (stb[i]) begin
                    if (ack_seen[i] || $urandom_range(0, 199) == 0) stb[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    stb[i] = 1'b1;
                    adr[i] = 23'($urandom);
                    we[i]  = 1'($urandom);
                end
            end
            look;
            ack_seen = ack;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
